// File: rtl/decode_scoreboard.sv
// decode_scoreboard: RAW/WAW hazard scoreboard for the scalar and vector register files, with a drain FSM.
// Optional macro SB_WB_BYPASS_EN: a same-cycle write-back masks the source-busy check.
`default_nettype none

module decode_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_src_vec,
    input  logic            id_wr_sc,
    input  logic            id_wr_vec,
    input  logic            flush,
    input  logic            wb_wr_sc,
    input  logic            wb_wr_vec,
    input  logic [AW-1:0]   wb_rd,
    input  logic            drain_req,
    output logic            stall,
    output logic            issue,
    output logic            drained,
    output logic            sb_err,
    output logic [NREG-1:0] pend_sc,
    output logic [NREG-1:0] pend_vec
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_DRAINED = 2'd2
    } state_t;

    state_t state;

    logic [NREG-1:0] clr_sc, clr_vec, set_sc, set_vec;
    logic [NREG-1:0] nxt_sc, nxt_vec, src_pend;
    logic            hazard, wb_err, all_clear;

    always_comb begin
        clr_sc  = '0;
        clr_vec = '0;
        set_sc  = '0;
        set_vec = '0;
        if (wb_wr_sc)  clr_sc[wb_rd]  = 1'b1;
        if (wb_wr_vec) clr_vec[wb_rd] = 1'b1;

        src_pend = id_src_vec ? pend_vec : pend_sc;
`ifdef SB_WB_BYPASS_EN
        // Register file writes before it reads, so a retiring producer is already visible.
        src_pend = src_pend & ~(id_src_vec ? clr_vec : clr_sc);
`endif

        hazard = id_valid & ((id_use_rs1 & src_pend[id_rs1]) |
                             (id_use_rs2 & src_pend[id_rs2]) |
                             (id_wr_sc   & pend_sc[id_rd])   |
                             (id_wr_vec  & pend_vec[id_rd]));
        issue  = id_valid & ~hazard & ~flush & (state == S_RUN);
        stall  = id_valid & ~issue & ~flush;

        if (issue & id_wr_sc)  set_sc[id_rd]  = 1'b1;
        if (issue & id_wr_vec) set_vec[id_rd] = 1'b1;

        // Set wins over clear: the newly issued producer is younger than the retiring one.
        nxt_sc  = (pend_sc  & ~clr_sc)  | set_sc;
        nxt_vec = (pend_vec & ~clr_vec) | set_vec;

        wb_err = (wb_wr_sc  & ~pend_sc[wb_rd]  & ~set_sc[wb_rd]) |
                 (wb_wr_vec & ~pend_vec[wb_rd] & ~set_vec[wb_rd]);
        all_clear = ~(|nxt_sc) & ~(|nxt_vec);
    end

    assign drained = (state == S_DRAINED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_sc  <= '0;
            pend_vec <= '0;
            sb_err   <= 1'b0;
            state    <= S_RUN;
        end else begin
            pend_sc  <= nxt_sc;
            pend_vec <= nxt_vec;
            if (wb_err) sb_err <= 1'b1;
            case (state)
                S_RUN: begin
                    if (drain_req) state <= all_clear ? S_DRAINED : S_DRAIN;
                end
                S_DRAIN: begin
                    if (!drain_req)     state <= S_RUN;
                    else if (all_clear) state <= S_DRAINED;
                end
                S_DRAINED: begin
                    if (!drain_req) state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
// Directed scoreboard bench for decode_scoreboard; expectations are queued at drive time and popped at sample time.
`default_nettype none

module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_src_vec, id_wr_sc, id_wr_vec;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        flush, wb_wr_sc, wb_wr_vec, drain_req;
    logic        stall, issue, drained, sb_err;
    logic [31:0] pend_sc, pend_vec;

    int checks = 0;
    int errors = 0;

    string      tag_q[$];
    logic [3:0] exp_q[$];

    decode_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_src_vec(id_src_vec),
        .id_wr_sc(id_wr_sc), .id_wr_vec(id_wr_vec), .flush(flush),
        .wb_wr_sc(wb_wr_sc), .wb_wr_vec(wb_wr_vec), .wb_rd(wb_rd),
        .drain_req(drain_req),
        .stall(stall), .issue(issue), .drained(drained), .sb_err(sb_err),
        .pend_sc(pend_sc), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    task automatic clr_in();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_src_vec = 0;
        id_wr_sc = 0; id_wr_vec = 0; flush = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        wb_wr_sc = 0; wb_wr_vec = 0; wb_rd = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    // Expected flags ordered {stall, issue, drained, sb_err}.
    task automatic chk(input string tag, input logic [3:0] e);
        string      t;
        logic [3:0] x;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        #2;
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        checks++;
        assert ({stall, issue, drained, sb_err} === x)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", t, {stall, issue, drained, sb_err}, x);
        end
    endtask

    task automatic chkp(input string tag, input logic [31:0] esc, input logic [31:0] evec);
        checks++;
        assert (pend_sc === esc && pend_vec === evec)
        else begin
            errors++;
            $error("FAIL %s observed sc=%h vec=%h expected sc=%h vec=%h", tag, pend_sc, pend_vec, esc, evec);
        end
    endtask

    task automatic dep_rd5();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_wr_sc = 1; id_rd = 6;
    endtask

    initial begin
        rst = 0;
        drain_req = 0;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 4'b0000);
        chkp("reset_pend", 32'h0, 32'h0);
        @(posedge clk); #1; rst = 1;

        // Producer rd=5, then a dependent reader.
        nxt(); id_valid = 1; id_wr_sc = 1; id_rd = 5; id_use_rs1 = 1; id_rs1 = 1;
        chk("issue_rd5", 4'b0100);
        nxt(); dep_rd5();
        chk("raw_stall1", 4'b1000);
        chkp("pend_rd5", 32'h0000_0020, 32'h0);
        nxt(); dep_rd5();
        chk("raw_stall2", 4'b1000);
        nxt(); dep_rd5(); wb_wr_sc = 1; wb_rd = 5;
`ifdef SB_WB_BYPASS_EN
        chk("wb_bypass_issue", 4'b0100);
        nxt();
        chk("after_bypass", 4'b0000);
`else
        chk("wb_no_bypass", 4'b1000);
        nxt(); dep_rd5();
        chk("issue_after_wb", 4'b0100);
`endif
        nxt();
        chk("idle", 4'b0000);
        chkp("pend_rd6", 32'h0000_0040, 32'h0);
        wb_wr_sc = 1; wb_rd = 6;
        nxt();
        chkp("pend_clear", 32'h0, 32'h0);

        // Vector pending must not block a scalar source.
        id_valid = 1; id_wr_vec = 1; id_rd = 5;
        chk("issue_vec5", 4'b0100);
        nxt(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
        chk("scalar_src_indep", 4'b0100);
        chkp("pend_vec5", 32'h0, 32'h0000_0020);
        nxt(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 5; id_src_vec = 1;
        chk("vec_src_stall", 4'b1000);
        nxt(); id_valid = 1; id_wr_vec = 1; id_rd = 5; wb_wr_sc = 1; wb_rd = 0;
        wb_wr_sc = 0;
        chk("vec_waw_stall", 4'b1000);
        nxt(); wb_wr_vec = 1; wb_rd = 5;

        // Set and clear of the same bit in one cycle: set wins, no error.
        nxt(); id_valid = 1; id_wr_vec = 1; id_rd = 3; wb_wr_vec = 1; wb_rd = 3;
        chkp("vec_cleared", 32'h0, 32'h0);
        chk("set_clr_issue", 4'b0100);
        nxt();
        chk("set_clr_noerr", 4'b0000);
        chkp("set_wins", 32'h0, 32'h0000_0008);
        wb_wr_vec = 1; wb_rd = 3;

        // Flush: no stall, no issue, no set.
        nxt(); id_valid = 1; id_wr_sc = 1; id_rd = 7; flush = 1;
        chk("flush", 4'b0000);
        nxt();
        chkp("flush_noset", 32'h0, 32'h0);

        // Drain with a pending scalar write.
        id_valid = 1; id_wr_sc = 1; id_rd = 2;
        chk("issue_rd2", 4'b0100);
        nxt(); drain_req = 1;
        chk("drain_req_run", 4'b0000);
        nxt(); id_valid = 1; id_wr_sc = 1; id_rd = 8;
        chk("drain_block", 4'b1000);
        nxt(); id_valid = 1; id_wr_sc = 1; id_rd = 8; wb_wr_sc = 1; wb_rd = 2;
        chk("drain_wb", 4'b1000);
        nxt();
        chk("drained", 4'b0010);
        nxt(); drain_req = 0;
        chk("drained_release", 4'b0010);
        nxt(); id_valid = 1; id_wr_sc = 1; id_rd = 8;
        chk("back_to_run", 4'b0100);
        nxt(); wb_wr_sc = 1; wb_rd = 8;
        nxt(); drain_req = 1;
        chk("drain_empty_req", 4'b0000);
        nxt();
        chk("drain_direct", 4'b0010);
        chkp("drained_pend", 32'h0, 32'h0);
        drain_req = 0;

        // Write-back to a non-pending register is a sticky error.
        nxt(); nxt(); wb_wr_sc = 1; wb_rd = 9;
        chk("err_cycle", 4'b0000);
        nxt();
        chk("err_set", 4'b0001);
        nxt(); nxt();
        chk("err_sticky", 4'b0001);
        rst = 0;
        #1;
        chk("err_reset", 4'b0000);
        rst = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
